// File: rtl/inst_loader.sv
// Boot-time program loader: takes a byte stream (16-bit LE word count, then LE words),
// writes each assembled word into instruction memory, and holds the CPU in reset until done.
module inst_loader #(
   parameter int INST_SIZE = 32,
   parameter int ADDR_W    = 10,
   parameter int MAX_WORDS = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [7:0]           in_data,
   output logic                 in_ready,
   input  logic                 start,
   output logic                 im_we,
   output logic [ADDR_W-1:0]    im_addr,
   output logic [INST_SIZE-1:0] im_wdata,
   output logic                 cpu_rst_n,
   output logic                 done,
   output logic                 err,
   output logic [15:0]          words_loaded
);

   typedef enum logic [2:0] {
      S_HDR0,
      S_HDR1,
      S_LOAD,
      S_DONE,
      S_ERROR
   } state_t;

   localparam int         ASM_W = INST_SIZE - 8;
   localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

   state_t               state_q, state_d;
   logic [15:0]          count_q, count_d;
   logic [15:0]          idx_q, idx_d;
   logic [1:0]           lane_q, lane_d;
   logic [ASM_W-1:0]     asm_q, asm_d;
   logic                 in_ready_q, in_ready_d;
   logic                 im_we_q, im_we_d;
   logic [ADDR_W-1:0]    im_addr_q, im_addr_d;
   logic [INST_SIZE-1:0] im_wdata_q, im_wdata_d;
   logic                 cpu_rst_n_q, cpu_rst_n_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic [15:0]          words_q, words_d;

   logic                 xfer;
   logic [15:0]          hdr_n;

   assign xfer  = in_valid && in_ready_q;
   assign hdr_n = {in_data, count_q[7:0]};

   // done/cpu_rst_n/err are recomputed each cycle from the state, so they rise
   // one edge after DONE/ERROR is entered and fall at the edge that sees start.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      idx_d       = idx_q;
      lane_d      = lane_q;
      asm_d       = asm_q;
      im_we_d     = 1'b0;
      im_addr_d   = im_addr_q;
      im_wdata_d  = im_wdata_q;
      words_d     = words_q;
      done_d      = 1'b0;
      cpu_rst_n_d = 1'b0;
      err_d       = 1'b0;

      case (state_q)
         S_HDR0: begin
            if (xfer) begin
               count_d = {8'h00, in_data};
               state_d = S_HDR1;
            end
         end

         S_HDR1: begin
            if (xfer) begin
               count_d = hdr_n;
               if (hdr_n == 16'd0) begin
                  state_d = S_DONE;
               end else if ({1'b0, hdr_n} > MAX_W) begin
                  state_d = S_ERROR;
               end else begin
                  state_d = S_LOAD;
                  idx_d   = 16'd0;
                  lane_d  = 2'd0;
               end
            end
         end

         S_LOAD: begin
            if (xfer) begin
               lane_d = lane_q + 2'd1;
               case (lane_q)
                  2'd0: asm_d[7:0]   = in_data;
                  2'd1: asm_d[15:8]  = in_data;
                  2'd2: asm_d[23:16] = in_data;
                  default: begin
                     im_we_d    = 1'b1;
                     im_addr_d  = idx_q[ADDR_W-1:0];
                     im_wdata_d = {in_data, asm_q};
                     idx_d      = idx_q + 16'd1;
                     words_d    = words_q + 16'd1;
                     if (idx_q + 16'd1 == count_q) begin
                        state_d = S_DONE;
                     end
                  end
               endcase
            end
         end

         S_DONE: begin
            if (start) begin
               state_d = S_HDR0;
               count_d = 16'd0;
               idx_d   = 16'd0;
               lane_d  = 2'd0;
               asm_d   = '0;
               words_d = 16'd0;
            end else begin
               done_d      = 1'b1;
               cpu_rst_n_d = 1'b1;
            end
         end

         S_ERROR: begin
            if (start) begin
               state_d = S_HDR0;
               count_d = 16'd0;
               idx_d   = 16'd0;
               lane_d  = 2'd0;
               asm_d   = '0;
               words_d = 16'd0;
            end else begin
               err_d = 1'b1;
            end
         end

         default: state_d = S_HDR0;
      endcase

      in_ready_d = (state_d == S_HDR0) || (state_d == S_HDR1) || (state_d == S_LOAD);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_HDR0;
         count_q     <= 16'd0;
         idx_q       <= 16'd0;
         lane_q      <= 2'd0;
         asm_q       <= '0;
         in_ready_q  <= 1'b0;
         im_we_q     <= 1'b0;
         im_addr_q   <= '0;
         im_wdata_q  <= '0;
         cpu_rst_n_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         words_q     <= 16'd0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         idx_q       <= idx_d;
         lane_q      <= lane_d;
         asm_q       <= asm_d;
         in_ready_q  <= in_ready_d;
         im_we_q     <= im_we_d;
         im_addr_q   <= im_addr_d;
         im_wdata_q  <= im_wdata_d;
         cpu_rst_n_q <= cpu_rst_n_d;
         done_q      <= done_d;
         err_q       <= err_d;
         words_q     <= words_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign im_we        = im_we_q;
   assign im_addr      = im_addr_q;
   assign im_wdata     = im_wdata_q;
   assign cpu_rst_n    = cpu_rst_n_q;
   assign done         = done_q;
   assign err          = err_q;
   assign words_loaded = words_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: captures every im_we write and compares the
// captured writes and status outputs against hand-computed expectations.
module tb_inst_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        start;
   logic        im_we;
   logic [9:0]  im_addr;
   logic [31:0] im_wdata;
   logic        cpu_rst_n;
   logic        done;
   logic        err;
   logic [15:0] words_loaded;

   typedef struct {
      logic [9:0]  a;
      logic [31:0] d;
   } wr_t;

   wr_t wq[$];
   int  n_xfer   = 0;
   int  n_checks = 0;
   int  n_pass   = 0;

   inst_loader #(.INST_SIZE(32), .ADDR_W(10), .MAX_WORDS(1024)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .start(start), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
      .cpu_rst_n(cpu_rst_n), .done(done), .err(err), .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   // Inputs only change just after rising edges, so the falling edge sees what the next edge will see.
   always @(negedge clk) begin
      wr_t w;
      if (im_we) begin
         w.a = im_addr;
         w.d = im_wdata;
         wq.push_back(w);
      end
      if (in_valid && in_ready) n_xfer++;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic send_byte(input logic [7:0] b);
      bit ok;
      int guard;
      in_valid = 1'b1;
      in_data  = b;
      ok       = 1'b0;
      guard    = 0;
      while (!ok && guard < 50) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         guard++;
      end
      if (!ok) begin
         n_checks++;
         $display("[TB] FAIL send_byte: in_ready stuck at 0 for byte %02h, required 1", b);
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_data  = 8'h5A;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready: got %0h required 0", in_ready); else n_pass++;
      n_checks++; if (im_we !== 1'b0) $display("[TB] FAIL reset_im_we: got %0h required 0", im_we); else n_pass++;
      n_checks++; if (im_addr !== 10'd0) $display("[TB] FAIL reset_im_addr: got %0h required 0", im_addr); else n_pass++;
      n_checks++; if (im_wdata !== 32'd0) $display("[TB] FAIL reset_im_wdata: got %0h required 0", im_wdata); else n_pass++;
      n_checks++; if (cpu_rst_n !== 1'b0) $display("[TB] FAIL reset_cpu_rst_n: got %0h required 0", cpu_rst_n); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %0h required 0", done); else n_pass++;
      n_checks++; if (err !== 1'b0) $display("[TB] FAIL reset_err: got %0h required 0", err); else n_pass++;
      n_checks++; if (words_loaded !== 16'd0) $display("[TB] FAIL reset_words_loaded: got %0h required 0", words_loaded); else n_pass++;
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_checks++; if (in_ready !== 1'b1) $display("[TB] FAIL ready_after_reset: got %0h required 1", in_ready); else n_pass++;
   endtask

   task automatic test_two_word();
      logic [7:0] bytes [10] = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      int x0;
      wq.delete();
      foreach (bytes[i]) send_byte(bytes[i]);
      n_checks++; if (im_we !== 1'b1) $display("[TB] FAIL two_last_we: got %0h required 1", im_we); else n_pass++;
      n_checks++; if (im_addr !== 10'd1) $display("[TB] FAIL two_last_addr: got %0h required 1", im_addr); else n_pass++;
      n_checks++; if (im_wdata !== 32'hDEADBEEF) $display("[TB] FAIL two_last_data: got %0h required deadbeef", im_wdata); else n_pass++;
      n_checks++; if (in_ready !== 1'b0) $display("[TB] FAIL two_ready_drop: got %0h required 0", in_ready); else n_pass++;
      n_checks++; if (cpu_rst_n !== 1'b0) $display("[TB] FAIL two_cpu_held: got %0h required 0", cpu_rst_n); else n_pass++;
      in_valid = 1'b1;
      in_data  = 8'h77;
      x0       = n_xfer;
      @(posedge clk);
      #1;
      n_checks++; if (im_we !== 1'b0) $display("[TB] FAIL two_we_pulse: got %0h required 0", im_we); else n_pass++;
      n_checks++; if (cpu_rst_n !== 1'b1) $display("[TB] FAIL two_release: got %0h required 1", cpu_rst_n); else n_pass++;
      n_checks++; if (done !== 1'b1) $display("[TB] FAIL two_done: got %0h required 1", done); else n_pass++;
      n_checks++; if (words_loaded !== 16'd2) $display("[TB] FAIL two_words_loaded: got %0d required 2", words_loaded); else n_pass++;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      n_checks++; if (n_xfer !== x0) $display("[TB] FAIL done_no_consume: got %0d transfers required %0d", n_xfer, x0); else n_pass++;
      n_checks++; if (wq.size() !== 2) $display("[TB] FAIL two_write_count: got %0d required 2", wq.size()); else n_pass++;
      if (wq.size() == 2) begin
         n_checks++; if (wq[0].a !== 10'd0 || wq[0].d !== 32'h12345678) $display("[TB] FAIL two_write0: got (%0h,%0h) required (0,12345678)", wq[0].a, wq[0].d); else n_pass++;
         n_checks++; if (wq[1].a !== 10'd1 || wq[1].d !== 32'hDEADBEEF) $display("[TB] FAIL two_write1: got (%0h,%0h) required (1,deadbeef)", wq[1].a, wq[1].d); else n_pass++;
      end
   endtask

   task automatic test_reload();
      pulse_start();
      wq.delete();
      n_checks++; if (cpu_rst_n !== 1'b0) $display("[TB] FAIL reload_cpu_rst_n: got %0h required 0", cpu_rst_n); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("[TB] FAIL reload_done: got %0h required 0", done); else n_pass++;
      n_checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reload_ready: got %0h required 1", in_ready); else n_pass++;
      n_checks++; if (words_loaded !== 16'd0) $display("[TB] FAIL reload_words_clear: got %0d required 0", words_loaded); else n_pass++;
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'hDD); send_byte(8'hCC); send_byte(8'hBB); send_byte(8'hAA);
      idle(1);
      n_checks++; if (done !== 1'b1 || cpu_rst_n !== 1'b1) $display("[TB] FAIL reload_release: got done=%0h cpu_rst_n=%0h required 1/1", done, cpu_rst_n); else n_pass++;
      n_checks++; if (words_loaded !== 16'd1) $display("[TB] FAIL reload_words: got %0d required 1", words_loaded); else n_pass++;
      n_checks++; if (wq.size() !== 1) $display("[TB] FAIL reload_write_count: got %0d required 1", wq.size()); else n_pass++;
      if (wq.size() == 1) begin
         n_checks++; if (wq[0].a !== 10'd0 || wq[0].d !== 32'hAABBCCDD) $display("[TB] FAIL reload_write0: got (%0h,%0h) required (0,aabbccdd)", wq[0].a, wq[0].d); else n_pass++;
      end
   endtask

   task automatic test_empty();
      pulse_start();
      wq.delete();
      send_byte(8'h00); send_byte(8'h00);
      in_valid = 1'b0;
      n_checks++; if (in_ready !== 1'b0) $display("[TB] FAIL empty_ready: got %0h required 0", in_ready); else n_pass++;
      n_checks++; if (cpu_rst_n !== 1'b0 || done !== 1'b0) $display("[TB] FAIL empty_early: got done=%0h cpu_rst_n=%0h required 0/0", done, cpu_rst_n); else n_pass++;
      idle(1);
      n_checks++; if (cpu_rst_n !== 1'b1 || done !== 1'b1) $display("[TB] FAIL empty_release: got done=%0h cpu_rst_n=%0h required 1/1", done, cpu_rst_n); else n_pass++;
      idle(2);
      n_checks++; if (wq.size() !== 0) $display("[TB] FAIL empty_no_write: got %0d writes required 0", wq.size()); else n_pass++;
      n_checks++; if (words_loaded !== 16'd0) $display("[TB] FAIL empty_words: got %0d required 0", words_loaded); else n_pass++;
   endtask

   task automatic test_oversize();
      pulse_start();
      wq.delete();
      send_byte(8'h01); send_byte(8'h04);
      in_valid = 1'b0;
      n_checks++; if (in_ready !== 1'b0) $display("[TB] FAIL over_ready: got %0h required 0", in_ready); else n_pass++;
      n_checks++; if (err !== 1'b0) $display("[TB] FAIL over_err_early: got %0h required 0", err); else n_pass++;
      idle(1);
      n_checks++; if (err !== 1'b1) $display("[TB] FAIL over_err: got %0h required 1", err); else n_pass++;
      n_checks++; if (cpu_rst_n !== 1'b0 || done !== 1'b0) $display("[TB] FAIL over_cpu_held: got done=%0h cpu_rst_n=%0h required 0/0", done, cpu_rst_n); else n_pass++;
      n_checks++; if (in_ready !== 1'b0) $display("[TB] FAIL over_ready_low: got %0h required 0", in_ready); else n_pass++;
      idle(2);
      n_checks++; if (wq.size() !== 0) $display("[TB] FAIL over_no_write: got %0d writes required 0", wq.size()); else n_pass++;
      pulse_start();
      n_checks++; if (err !== 1'b0) $display("[TB] FAIL over_err_clear: got %0h required 0", err); else n_pass++;
      n_checks++; if (in_ready !== 1'b1) $display("[TB] FAIL over_ready_back: got %0h required 1", in_ready); else n_pass++;
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      idle(2);
      n_checks++; if (done !== 1'b1 || cpu_rst_n !== 1'b1) $display("[TB] FAIL over_reload_done: got done=%0h cpu_rst_n=%0h required 1/1", done, cpu_rst_n); else n_pass++;
      n_checks++; if (wq.size() !== 1) $display("[TB] FAIL over_reload_count: got %0d required 1", wq.size()); else n_pass++;
      if (wq.size() == 1) begin
         n_checks++; if (wq[0].a !== 10'd0 || wq[0].d !== 32'h04030201) $display("[TB] FAIL over_reload_write: got (%0h,%0h) required (0,4030201)", wq[0].a, wq[0].d); else n_pass++;
      end
   endtask

   task automatic test_bubbles();
      logic [7:0] bytes [14] = '{8'h03, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77,
                                 8'h66, 8'h55, 8'hCC, 8'hBB, 8'hAA, 8'h99};
      logic [31:0] exp_d [3] = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
      pulse_start();
      wq.delete();
      foreach (bytes[i]) begin
         send_byte(bytes[i]);
         idle(int'($urandom_range(0, 3)));
      end
      idle(2);
      n_checks++; if (done !== 1'b1 || words_loaded !== 16'd3) $display("[TB] FAIL bubble_done: got done=%0h words=%0d required 1/3", done, words_loaded); else n_pass++;
      n_checks++; if (wq.size() !== 3) $display("[TB] FAIL bubble_count: got %0d required 3", wq.size()); else n_pass++;
      if (wq.size() == 3) begin
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (wq[k].a !== 10'(k) || wq[k].d !== exp_d[k])
               $display("[TB] FAIL bubble_write%0d: got (%0h,%0h) required (%0h,%0h)", k, wq[k].a, wq[k].d, k, exp_d[k]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_max_words();
      logic [31:0] w;
      int bad;
      pulse_start();
      wq.delete();
      send_byte(8'h00); send_byte(8'h04);
      for (int k = 0; k < 1024; k++) begin
         w = 32'hC000_0000 | 32'(k);
         send_byte(w[7:0]); send_byte(w[15:8]); send_byte(w[23:16]); send_byte(w[31:24]);
      end
      idle(2);
      n_checks++; if (done !== 1'b1 || err !== 1'b0) $display("[TB] FAIL max_done: got done=%0h err=%0h required 1/0", done, err); else n_pass++;
      n_checks++; if (words_loaded !== 16'd1024) $display("[TB] FAIL max_words: got %0d required 1024", words_loaded); else n_pass++;
      n_checks++; if (wq.size() !== 1024) $display("[TB] FAIL max_count: got %0d required 1024", wq.size()); else n_pass++;
      if (wq.size() == 1024) begin
         bad = 0;
         for (int k = 0; k < 1024; k++)
            if (wq[k].a !== 10'(k) || wq[k].d !== (32'hC000_0000 | 32'(k))) bad++;
         n_checks++; if (bad !== 0) $display("[TB] FAIL max_contents: got %0d wrong writes required 0", bad); else n_pass++;
         n_checks++; if (wq[1023].a !== 10'h3FF) $display("[TB] FAIL max_last_addr: got %0h required 3ff", wq[1023].a); else n_pass++;
      end
   endtask

   task automatic test_reset_midload();
      pulse_start();
      send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b0 || im_we !== 1'b0) $display("[TB] FAIL mid_rst_ready_we: got %0h/%0h required 0/0", in_ready, im_we); else n_pass++;
      n_checks++; if (im_addr !== 10'd0 || im_wdata !== 32'd0) $display("[TB] FAIL mid_rst_addr_data: got %0h/%0h required 0/0", im_addr, im_wdata); else n_pass++;
      n_checks++; if (cpu_rst_n !== 1'b0 || done !== 1'b0 || err !== 1'b0) $display("[TB] FAIL mid_rst_status: got %0h/%0h/%0h required 0/0/0", cpu_rst_n, done, err); else n_pass++;
      n_checks++; if (words_loaded !== 16'd0) $display("[TB] FAIL mid_rst_words: got %0d required 0", words_loaded); else n_pass++;
      @(posedge clk);
      #1;
      rst = 1'b0;
      wq.delete();
      send_byte(8'h02); send_byte(8'h00);
      send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      idle(2);
      n_checks++; if (done !== 1'b1 || words_loaded !== 16'd2) $display("[TB] FAIL mid_reload_done: got done=%0h words=%0d required 1/2", done, words_loaded); else n_pass++;
      n_checks++; if (wq.size() !== 2) $display("[TB] FAIL mid_reload_count: got %0d required 2", wq.size()); else n_pass++;
      if (wq.size() == 2) begin
         n_checks++; if (wq[0].a !== 10'd0 || wq[0].d !== 32'hDDCCBBAA) $display("[TB] FAIL mid_reload_write0: got (%0h,%0h) required (0,ddccbbaa)", wq[0].a, wq[0].d); else n_pass++;
         n_checks++; if (wq[1].a !== 10'd1 || wq[1].d !== 32'h04030201) $display("[TB] FAIL mid_reload_write1: got (%0h,%0h) required (1,4030201)", wq[1].a, wq[1].d); else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_two_word();
      test_reload();
      test_empty();
      test_oversize();
      test_bubbles();
      test_max_words();
      test_reset_midload();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/inst_loader.md
# inst_loader

Boot-time program loader that sits directly upstream of the instruction memory and the single-cycle CPU. It receives a program as a byte stream over a valid/ready handshake, assembles little-endian 32-bit instructions, and writes them into the instruction memory write port. It holds the CPU in reset until the whole program has been written, then releases it.

## Interface

- `INST_SIZE`, 32: instruction width in bits; fixed at 32, four bytes per word.
- `ADDR_W`, 10: instruction-memory word-address width.
- `MAX_WORDS`, 1024: capacity in words; must be ≤ 2^ADDR_W.

Ports:

- `clk` in 1: sole clock; rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: byte on `in_data` is valid.
- `in_data` in 8: stream byte.
- `in_ready` out 1: loader can accept a byte; registered.
- `start` in 1: single-cycle pulse that restarts loading from DONE or ERROR.
- `im_we` out 1: instruction-memory write enable; one-cycle pulse per word.
- `im_addr` out ADDR_W: word index being written.
- `im_wdata` out INST_SIZE: instruction word.
- `cpu_rst_n` out 1: active-low reset to the CPU; low while loading.
- `done` out 1: program loaded, CPU running.
- `err` out 1: header word count out of range.
- `words_loaded` out 16: count of words written in the current load.

## Operation

- **Transfer rule:** a byte transfers on a rising edge where `in_valid && in_ready`. No other cycle consumes a byte.
- **Stream format:** 16-bit little-endian word count N, followed by 4·N instruction bytes. Each word is least-significant byte first: `im_wdata = {b3,b2,b1,b0}`.
- **States:** HDR0, HDR1, LOAD, DONE, ERROR. Reset enters HDR0.
- **HDR0:** the transferred byte becomes N[7:0]. Next state HDR1.
- **HDR1:** the transferred byte becomes N[15:8]. Then:
  - N == 0 → DONE.
  - N > MAX_WORDS → ERROR.
  - Otherwise → LOAD, with the word index and byte-lane counter cleared.
- **LOAD:**
  - Each transfer fills lane 0..3 in turn.
  - On the lane-3 transfer, at the same edge: `im_we` is set to 1, `im_addr` is set to the word index k, `im_wdata` is set to the assembled word, and the index increments.
  - If k == N−1, next state is DONE.
- **DONE:**
  - `in_ready` is 0 and bytes are ignored.
  - `done` and `cpu_rst_n` go to 1.
  - `start` → HDR0, with `cpu_rst_n` and `done` forced to 0 and all counters cleared.
- **ERROR:**
  - `in_ready` is 0, `err` is 1, `cpu_rst_n` stays 0.
  - `start` → HDR0 and `err` is cleared.
- **`start` outside DONE/ERROR:** ignored.
- **Address width:** `im_addr` equals the word index truncated to ADDR_W. It never wraps, because N ≤ MAX_WORDS is enforced.
- **`words_loaded`:** increments on each `im_we` pulse and is cleared on restart.

## Timing

- **Reset values (asynchronous):**
  - 0: `in_ready`, `im_we`, `im_addr`, `im_wdata`, `cpu_rst_n`, `done`, `err`, `words_loaded`.
  - State: HDR0.
- **`in_ready`:** registered. It is 1 from the first edge after `rst` deasserts while the state is HDR0, HDR1 or LOAD. It drops at the same edge where the state moves to DONE or ERROR.
- **`im_we`:** high for exactly one cycle following the lane-3 transfer edge. With back-to-back bytes the minimum spacing between pulses is 4 cycles.
- **Release sequence:**
  - The final word's `im_we` pulse coincides with the first DONE cycle.
  - `cpu_rst_n` and `done` rise one edge later.
  - This guarantees the last write completes before the CPU fetches.
- **N == 0 or N > MAX_WORDS:**
  - DONE or ERROR is entered at the HDR1 transfer edge.
  - For N == 0, `cpu_rst_n` rises at the following edge.
  - For N > MAX_WORDS, `err` rises at the following edge.
- **Bubbles:** gaps in `in_valid` stall assembly with no lane or index change.
- **Mid-load reset:** `rst` asserted mid-load aborts immediately. All partial state is discarded and `cpu_rst_n` is held low.

## Test plan

- **Two-word load:** N=2, bytes 0x02,0x00, 0x78,0x56,0x34,0x12, 0xEF,0xBE,0xAD,0xDE, `in_valid` held high → `im_we` pulses with (0, 0x12345678) and (1, 0xDEADBEEF); `cpu_rst_n` rises one cycle after the second pulse; `words_loaded` = 2.
- **Empty program:** N=0 (0x00,0x00) → no `im_we`; `done` = 1 and `cpu_rst_n` = 1 two edges after the second header byte.
- **Oversize count:** N=0x0401 with MAX_WORDS=1024 → `err` = 1, `in_ready` = 0, `cpu_rst_n` = 0 and no writes. A `start` pulse → `err` = 0 and a fresh N=1 load succeeds.
- **Backpressure and bubbles:** random `in_valid` gaps with N=3 → identical writes to the gap-free run; no byte is consumed while `in_ready` = 0 in DONE.
- **Reload:** after DONE, pulse `start` → `cpu_rst_n` = 0 the next cycle; reload N=1 with 0xAABBCCDD → write (0, 0xAABBCCDD), then release.
- **Reset mid-load:** assert `rst` after 6 bytes of an N=2 load → all outputs are 0 immediately; a full reload afterwards produces correct words starting at index 0.
